dreq_reply_reader: RTL and testbench



---
 rtl/dreq_pkg.sv | 22 ++
 rtl/dreq_reply_reader_halfword_shifter.sv | 49 ++++
 rtl/dreq_reply_reader.sv | 132 +++++++++++++
 tb/tb_dreq_reply_reader.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dreq_pkg.sv
// Shared definitions for the Data Request reply reader: FSM states,
// packet geometry and the default header marker.
package dreq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HDR   = 3'd2,
    ST_FETCH = 3'd3,
    ST_LOAD  = 3'd4,
    ST_SHIFT = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  localparam int unsigned HDR_LEN        = 8;
  localparam int unsigned HW_PER_WORD    = 4;
  localparam int unsigned WORDS_PER_PCKT = 2;
  localparam int unsigned HDR_WORDS      = HDR_LEN / HW_PER_WORD;

  localparam logic [15:0] HDR_MARKER_DEFAULT = 16'hDA7A;

endpackage

// File: rtl/dreq_reply_reader_halfword_shifter.sv
// 64-bit load/shift register emitting 16-bit halfwords LSB first under a
// valid/ready handshake; a load always wins over a shift in the same cycle.
module halfword_shifter
  import dreq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [63:0] load_data_i,
  input  logic        valid_i,
  input  logic        ready_i,
  output logic [15:0] data_o,
  output logic        last_o
);

  logic [63:0] sr_q, sr_d;
  logic [1:0]  idx_q, idx_d;

  // next-state: reload on load, otherwise advance one halfword per handshake
  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (load_i) begin
      sr_d  = load_data_i;
      idx_d = 2'd0;
    end else if (valid_i && ready_i) begin
      sr_d  = {16'h0000, sr_q[63:16]};
      idx_d = idx_q + 2'd1;
    end else begin
      sr_d  = sr_q;
      idx_d = idx_q;
    end
  end

  // shift register and halfword index
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= 64'h0000_0000_0000_0000;
      idx_q <= 2'd0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

  assign data_o = sr_q[15:0];
  assign last_o = (idx_q == 2'(HW_PER_WORD - 1));

endmodule

// File: rtl/dreq_reply_reader.sv
// Data Request reply reader: waits for a complete FIFO reply, then emits an
// 8-halfword header followed by the FIFO words as 16-bit halfwords.
module dreq_reply_reader
  import dreq_pkg::*;
#(
  parameter logic [15:0] HDR_MARKER = HDR_MARKER_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        DREQ_START,
  input  logic        MEMFIFO_DATA_READY,
  input  logic [15:0] MEMFIFO_DATA_PCKTS,
  input  logic [63:0] MEMFIFO_DATA,
  output logic        MEMFIFO_RE,
  output logic [15:0] TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        DREQ_BUSY,
  output logic        DREQ_DONE,
  output logic        DREQ_ERR
);

  state_e      state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic        hdr2_q, hdr2_d;
  logic        re_q, busy_q, done_q, err_q;
  logic        ld_s;
  logic [63:0] ld_data_s;
  logic        last_s;
  logic        fire_s;

  assign TX_VALID = (state_q == ST_HDR) || (state_q == ST_SHIFT);
  assign fire_s   = TX_VALID && TX_READY;

  halfword_shifter u_shifter (
    .clk_i       (CLK),
    .rst_ni      (RESET_N),
    .load_i      (ld_s),
    .load_data_i (ld_data_s),
    .valid_i     (TX_VALID),
    .ready_i     (TX_READY),
    .data_o      (TX_DATA),
    .last_o      (last_s)
  );

  // next-state, word counter and shifter load control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr2_d    = hdr2_q;
    ld_s      = 1'b0;
    ld_data_s = 64'h0000_0000_0000_0000;
    case (state_q)
      ST_IDLE: begin
        if (DREQ_START) state_d = ST_WAIT;
        else            state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (MEMFIFO_DATA_READY) begin
          state_d   = ST_HDR;
          cnt_d     = 17'(MEMFIFO_DATA_PCKTS) * 17'(WORDS_PER_PCKT);
          hdr2_d    = 1'b0;
          ld_s      = 1'b1;
          ld_data_s = {32'h0000_0000, MEMFIFO_DATA_PCKTS, HDR_MARKER};
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HDR: begin
        // header is two shifter words: marker/pckts, then all zeros
        if (fire_s && last_s) begin
          if (!hdr2_q) begin
            hdr2_d = 1'b1;
            ld_s   = 1'b1;
          end else if (cnt_q != 17'd0) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_FETCH: begin
        cnt_d   = cnt_q - 17'd1;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ld_s      = 1'b1;
        ld_data_s = MEMFIFO_DATA;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (fire_s && last_s) begin
          if (cnt_q != 17'd0) state_d = ST_FETCH;
          else                state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state, counters and registered strobes
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= 17'd0;
      hdr2_q  <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr2_q  <= hdr2_d;
      re_q    <= (state_d == ST_FETCH);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      err_q   <= DREQ_START && (state_q != ST_IDLE);
    end
  end

  assign MEMFIFO_RE = re_q;
  assign DREQ_BUSY  = busy_q;
  assign DREQ_DONE  = done_q;
  assign DREQ_ERR   = err_q;

endmodule

// File: tb/tb_dreq_reply_reader.sv
// Self-checking bench for dreq_reply_reader: FIFO responder, randomized
// backpressure and a queue-based reference of the expected halfword stream.
module tb_dreq_reply_reader;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        DREQ_START;
  logic        MEMFIFO_DATA_READY;
  logic [15:0] MEMFIFO_DATA_PCKTS;
  logic [63:0] MEMFIFO_DATA;
  logic        MEMFIFO_RE;
  logic [15:0] TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        DREQ_BUSY;
  logic        DREQ_DONE;
  logic        DREQ_ERR;

  int checks = 0;
  int failures = 0;

  logic [63:0] fifo[$];
  logic [15:0] exp[$];
  logic [15:0] got[$];
  int re_cnt, done_cnt, err_cnt, valid_cnt, stall_bad, cyc, last_hs_cyc, done_cyc;
  logic stall_prev = 1'b0;
  logic [15:0] stall_data;
  int ready_mode = 0;

  dreq_reply_reader dut (
    .CLK                (CLK),
    .RESET_N            (RESET_N),
    .DREQ_START         (DREQ_START),
    .MEMFIFO_DATA_READY (MEMFIFO_DATA_READY),
    .MEMFIFO_DATA_PCKTS (MEMFIFO_DATA_PCKTS),
    .MEMFIFO_DATA       (MEMFIFO_DATA),
    .MEMFIFO_RE         (MEMFIFO_RE),
    .TX_DATA            (TX_DATA),
    .TX_VALID           (TX_VALID),
    .TX_READY           (TX_READY),
    .DREQ_BUSY          (DREQ_BUSY),
    .DREQ_DONE          (DREQ_DONE),
    .DREQ_ERR           (DREQ_ERR)
  );

  always #5 CLK = ~CLK;

  // FIFO model: data valid the cycle after the read strobe
  always @(posedge CLK) begin
    if (MEMFIFO_RE) begin
      if (fifo.size() > 0) MEMFIFO_DATA <= fifo.pop_front();
      else                 MEMFIFO_DATA <= 64'h0;
    end
  end

  // SERDES ready pattern
  always @(posedge CLK) begin
    #1;
    case (ready_mode)
      1:       TX_READY = ~TX_READY;
      2:       TX_READY = 1'($urandom_range(0, 1));
      default: TX_READY = 1'b1;
    endcase
  end

  // monitor: handshakes, strobes and stall stability
  always @(negedge CLK) begin
    cyc++;
    if (RESET_N) begin
      if (TX_VALID && TX_READY) begin
        got.push_back(TX_DATA);
        last_hs_cyc = cyc;
      end
      if (TX_VALID) valid_cnt++;
      if (MEMFIFO_RE) re_cnt++;
      if (DREQ_ERR) err_cnt++;
      if (DREQ_DONE) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (stall_prev && (!TX_VALID || TX_DATA !== stall_data)) stall_bad++;
      stall_prev = TX_VALID && !TX_READY;
      stall_data = TX_DATA;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic clear_mon();
    got.delete(); exp.delete(); fifo.delete();
    re_cnt = 0; done_cnt = 0; err_cnt = 0; valid_cnt = 0; stall_bad = 0;
    last_hs_cyc = -100; done_cyc = -200;
  endtask

  task automatic expect_header(input logic [15:0] p);
    exp.push_back(16'hDA7A);
    exp.push_back(p);
    repeat (6) exp.push_back(16'h0000);
  endtask

  task automatic add_word(input logic [63:0] w);
    fifo.push_back(w);
    for (int k = 0; k < 4; k++) exp.push_back(w[16*k +: 16]);
  endtask

  task automatic add_random_packets(input int p);
    logic [63:0] w;
    for (int i = 0; i < 2 * p; i++) begin
      w = {$urandom(), $urandom()};
      add_word(w);
    end
  endtask

  task automatic start_req(input logic [15:0] p);
    MEMFIFO_DATA_PCKTS = p;
    @(posedge CLK); #1 DREQ_START = 1'b1;
    @(posedge CLK); #1 DREQ_START = 1'b0;
    checks++;
    if (DREQ_BUSY !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_start got=%b exp=1", DREQ_BUSY);
    end
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL done_timeout got=no_done exp=done within %0d cycles", bound);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_reply(input string name, input int p);
    int bad = -1;
    checks++;
    if (got.size() != exp.size()) begin
      failures++;
      $display("FAIL %s_len got=%0d exp=%0d", name, got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++)
        if (got[i] !== exp[i] && bad < 0) bad = i;
      checks++;
      if (bad >= 0) begin
        failures++;
        $display("FAIL %s_data idx=%0d got=%h exp=%h", name, bad, got[bad], exp[bad]);
      end
    end
    checks++;
    if (re_cnt != 2 * p) begin
      failures++;
      $display("FAIL %s_re_count got=%0d exp=%0d", name, re_cnt, 2 * p);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL %s_done_count got=%0d exp=1", name, done_cnt);
    end
    checks++;
    if (done_cyc != last_hs_cyc + 1) begin
      failures++;
      $display("FAIL %s_done_timing got=%0d exp=%0d", name, done_cyc, last_hs_cyc + 1);
    end
    checks++;
    if (stall_bad != 0) begin
      failures++;
      $display("FAIL %s_stall_stable got=%0d exp=0", name, stall_bad);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({MEMFIFO_RE, TX_DATA, TX_VALID, DREQ_BUSY, DREQ_DONE, DREQ_ERR} !== 21'h0) begin
      failures++;
      $display("FAIL %s got=re%b data%h v%b b%b d%b e%b exp=all zero", name,
               MEMFIFO_RE, TX_DATA, TX_VALID, DREQ_BUSY, DREQ_DONE, DREQ_ERR);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; DREQ_START = 1'b0; MEMFIFO_DATA_READY = 1'b0;
    MEMFIFO_DATA_PCKTS = 16'h0; MEMFIFO_DATA = 64'h0; TX_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1 check_outputs_zero("reset_held");
    RESET_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1 check_outputs_zero("reset_released");
  endtask

  task automatic test_zero_packets();
    clear_mon(); ready_mode = 0;
    MEMFIFO_DATA_READY = 1'b1;
    expect_header(16'h0000);
    start_req(16'h0000);
    wait_done(200);
    check_reply("zero", 0);
  endtask

  task automatic test_one_packet();
    clear_mon(); ready_mode = 0;
    MEMFIFO_DATA_READY = 1'b1;
    expect_header(16'h0001);
    add_word(64'h0123456789ABCDEF);
    add_word(64'hFEDCBA9876543210);
    start_req(16'h0001);
    wait_done(200);
    check_reply("one", 1);
  endtask

  task automatic test_backpressure();
    clear_mon(); ready_mode = 1;
    MEMFIFO_DATA_READY = 1'b1;
    expect_header(16'h0003);
    add_random_packets(3);
    start_req(16'h0003);
    wait_done(1000);
    check_reply("backpressure", 3);
    ready_mode = 0;
  endtask

  task automatic test_late_ready();
    clear_mon(); ready_mode = 0;
    MEMFIFO_DATA_READY = 1'b0;
    expect_header(16'h0001);
    add_random_packets(1);
    start_req(16'h0001);
    repeat (50) @(posedge CLK);
    checks++;
    if (valid_cnt != 0) begin
      failures++;
      $display("FAIL late_no_valid got=%0d exp=0", valid_cnt);
    end
    #1 MEMFIFO_DATA_READY = 1'b1;
    @(negedge CLK);
    checks++;
    if (TX_VALID !== 1'b0) begin
      failures++;
      $display("FAIL late_ready_cycle got=%b exp=0", TX_VALID);
    end
    @(negedge CLK);
    checks++;
    if (TX_VALID !== 1'b1 || TX_DATA !== 16'hDA7A) begin
      failures++;
      $display("FAIL late_first_hdr got=v%b/%h exp=v1/da7a", TX_VALID, TX_DATA);
    end
    MEMFIFO_DATA_PCKTS = 16'h0005;
    MEMFIFO_DATA_READY = 1'b0;
    wait_done(200);
    check_reply("late", 1);
  endtask

  task automatic test_busy_request();
    int n = 0;
    clear_mon(); ready_mode = 0;
    MEMFIFO_DATA_READY = 1'b1;
    expect_header(16'h0002);
    add_random_packets(2);
    start_req(16'h0002);
    while (re_cnt == 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1 DREQ_START = 1'b1;
    @(posedge CLK); #1 DREQ_START = 1'b0;
    wait_done(300);
    check_reply("busy", 2);
    checks++;
    if (err_cnt != 1) begin
      failures++;
      $display("FAIL busy_err_count got=%0d exp=1", err_cnt);
    end
    // request landing exactly in the DONE cycle
    clear_mon();
    expect_header(16'h0000);
    start_req(16'h0000);
    n = 0;
    while (!DREQ_DONE && n < 100) begin
      @(negedge CLK);
      n++;
    end
    DREQ_START = 1'b1;
    @(posedge CLK); #1 DREQ_START = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (err_cnt != 1 || DREQ_BUSY !== 1'b0) begin
      failures++;
      $display("FAIL done_cycle_start got=err%0d/busy%b exp=err1/busy0", err_cnt, DREQ_BUSY);
    end
  endtask

  task automatic test_reset_mid_shift();
    int n = 0;
    clear_mon(); ready_mode = 0;
    MEMFIFO_DATA_READY = 1'b1;
    add_random_packets(2);
    start_req(16'h0002);
    while (re_cnt == 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1 RESET_N = 1'b0;
    #1 check_outputs_zero("reset_mid_shift");
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    clear_mon();
    expect_header(16'h0002);
    add_random_packets(2);
    start_req(16'h0002);
    wait_done(300);
    check_reply("after_reset", 2);
  endtask

  task automatic test_random();
    int p;
    for (int it = 0; it < 4; it++) begin
      clear_mon(); ready_mode = 2;
      MEMFIFO_DATA_READY = 1'b1;
      p = int'($urandom_range(0, 4));
      expect_header(16'(p));
      add_random_packets(p);
      start_req(16'(p));
      wait_done(2000);
      check_reply("random", p);
    end
    ready_mode = 0;
  endtask

  initial begin
    test_reset();
    test_zero_packets();
    test_one_packet();
    test_backpressure();
    test_late_ready();
    test_busy_request();
    test_reset_mid_shift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
